// File: rtl/eth_port_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// eth_port_tx
//   Store-and-forward transmit buffer for one switch egress port. Words from
//   the switch core are written into a circular buffer. A packet becomes
//   eligible for transmission only once its eop word has been stored. Broken
//   packets are discarded and counted in errCount. A broken packet is one cut
//   short by a new sop, or one too large to ever fit in the buffer.
//
// Ports
//   clk        single clock, all state changes on its rising edge
//   reset      asynchronous active-high reset
//   wrData     packet word from the switch core
//   wrSop      start-of-packet marker (qualified by wrValid)
//   wrEop      end-of-packet marker (qualified by wrValid)
//   wrValid    write word valid this cycle
//   wrReady    buffer accepts a word this cycle (transfer = wrValid & wrReady)
//   portStall  line-side backpressure
//   outData    transmitted word (registered)
//   outSop     first word of the outgoing packet (registered)
//   outEop     last word of the outgoing packet (registered)
//   outValid   outData/outSop/outEop valid this cycle (registered)
//   errCount   dropped-packet counter, saturates at 255
// -----------------------------------------------------------------------------
module eth_port_tx #(
  parameter int DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] wrData,
  input  logic        wrSop,
  input  logic        wrEop,
  input  logic        wrValid,
  output logic        wrReady,
  input  logic        portStall,
  output logic [31:0] outData,
  output logic        outSop,
  output logic        outEop,
  output logic        outValid,
  output logic [7:0]  errCount
);

  localparam int AW = $clog2(DEPTH);
  // Pointers carry one extra wrap bit so that full and empty can be told apart.
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  localparam logic [1:0] WR_IDLE = 2'd0;
  localparam logic [1:0] WR_PKT  = 2'd1;
  localparam logic [1:0] WR_DROP = 2'd2;

  localparam logic [0:0] TX_IDLE = 1'b0;
  localparam logic [0:0] TX_SEND = 1'b1;

  // Each entry is {sop, eop, data}.
  logic [33:0]   mem [DEPTH];

  logic [1:0]    wrState, wrStateNext;
  logic [0:0]    txState;
  logic [PW-1:0] wrPtr, wrPtrNext;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] startPtr, startPtrNext;
  logic [PW-1:0] pktCount;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] wrAddr;
  logic [33:0]   wrWord;
  logic [33:0]   rdWord;
  logic          full;
  logic          wrFire;
  logic          wrEn;
  logic          pktInc;
  logic          errInc;
  logic          popEn;
  logic          popEop;

  assign occupancy = wrPtr - rdPtr;
  assign full      = (occupancy == DEPTH_P);
  // While dropping an oversize packet, the remaining words are swallowed at
  // full rate. This lets the sender reach the eop without waiting on space.
  assign wrReady   = (wrState == WR_DROP) || !full;
  assign wrFire    = wrValid && wrReady;
  assign wrWord    = {wrSop, wrEop, wrData};

  assign rdWord    = mem[rdPtr[AW-1:0]];
  // In TX_SEND the rest of the current packet is already stored, so a pop
  // needs only the line to be free.
  assign popEn     = !portStall && ((txState == TX_SEND) || (pktCount != '0));
  assign popEop    = popEn && rdWord[32];

  // Write-side decisions: where the incoming word lands, and how the write
  // pointer moves. A discarded partial packet is rolled back to the start
  // pointer. The read side never touches an incomplete packet, so this
  // rollback can never cross the read pointer.
  always_comb begin
    wrStateNext  = wrState;
    wrPtrNext    = wrPtr;
    startPtrNext = startPtr;
    wrAddr       = wrPtr;
    wrEn         = 1'b0;
    pktInc       = 1'b0;
    errInc       = 1'b0;
    case (wrState)
      WR_IDLE, WR_DROP: begin
        if (wrFire) begin
          if (wrSop) begin
            wrEn         = 1'b1;
            wrAddr       = wrPtr;
            startPtrNext = wrPtr;
            wrPtrNext    = wrPtr + PTR_ONE;
            if (wrEop) begin
              pktInc      = 1'b1;
              wrStateNext = WR_IDLE;
            end else begin
              wrStateNext = WR_PKT;
            end
          end else if (wrState == WR_DROP && wrEop) begin
            wrStateNext = WR_IDLE;
          end
        end
      end
      WR_PKT: begin
        if (full && (pktCount == '0)) begin
          // The whole buffer holds one unfinished packet, so it can never
          // complete. Discard it and skip its remaining words.
          wrPtrNext   = startPtr;
          errInc      = 1'b1;
          wrStateNext = WR_DROP;
        end else if (wrFire) begin
          wrEn = 1'b1;
          if (wrSop) begin
            // A new sop cuts the current packet short. Rewind and start over
            // at the same slot.
            errInc    = 1'b1;
            wrAddr    = startPtr;
            wrPtrNext = startPtr + PTR_ONE;
          end else begin
            wrAddr    = wrPtr;
            wrPtrNext = wrPtr + PTR_ONE;
          end
          if (wrEop) begin
            pktInc      = 1'b1;
            wrStateNext = WR_IDLE;
          end
        end
      end
      default: begin
        wrStateNext = WR_IDLE;
      end
    endcase
  end

  // Write FSM, write pointer, packet start pointer and the saturating drop counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrState  <= WR_IDLE;
      wrPtr    <= '0;
      startPtr <= '0;
      errCount <= 8'd0;
    end else begin
      wrState  <= wrStateNext;
      wrPtr    <= wrPtrNext;
      startPtr <= startPtrNext;
      if (errInc && (errCount != 8'hFF)) begin
        errCount <= errCount + 8'd1;
      end
    end
  end

  // Packet storage. The storage is not reset; stale contents are unreachable
  // because the read side only follows completed packets.
  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr[AW-1:0]] <= wrWord;
    end
  end

  // Completed-packet count. A completion and a departure in the same cycle
  // cancel each other out.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pktCount <= '0;
    end else begin
      case ({pktInc, popEop})
        2'b10:   pktCount <= pktCount + PTR_ONE;
        2'b01:   pktCount <= pktCount - PTR_ONE;
        default: pktCount <= pktCount;
      endcase
    end
  end

  // Read FSM and registered line outputs. During a stall, outValid drops and
  // the last word is held on outData/outSop/outEop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      txState  <= TX_IDLE;
      rdPtr    <= '0;
      outData  <= 32'd0;
      outSop   <= 1'b0;
      outEop   <= 1'b0;
      outValid <= 1'b0;
    end else if (popEn) begin
      rdPtr    <= rdPtr + PTR_ONE;
      outData  <= rdWord[31:0];
      outSop   <= rdWord[33];
      outEop   <= rdWord[32];
      outValid <= 1'b1;
      txState  <= rdWord[32] ? TX_IDLE : TX_SEND;
    end else begin
      outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_eth_port_tx.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_eth_port_tx
//   Self-checking bench for eth_port_tx. A packet-level reference model decides
//   which packets should reach the line and how many drops should be counted.
//   A monitor records every word that leaves the block.
// -----------------------------------------------------------------------------
module tb_eth_port_tx;

  localparam int DEPTH  = 16;
  localparam int BUDGET = 4000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] wrData;
  logic        wrSop;
  logic        wrEop;
  logic        wrValid;
  logic        wrReady;
  logic        portStall;
  logic [31:0] outData;
  logic        outSop;
  logic        outEop;
  logic        outValid;
  logic [7:0]  errCount;

  int          passedChecks = 0;
  int          failedChecks = 0;
  int          totalChecks  = 0;
  int          errExp       = 0;
  int          cycleCount   = 0;
  bit          randStall    = 1'b0;

  // Expected and observed line words, each {sop, eop, data}.
  logic [33:0] expQ[$];
  logic [33:0] obsQ[$];
  int          obsCyc[$];

  eth_port_tx #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .wrData    (wrData),
    .wrSop     (wrSop),
    .wrEop     (wrEop),
    .wrValid   (wrValid),
    .wrReady   (wrReady),
    .portStall (portStall),
    .outData   (outData),
    .outSop    (outSop),
    .outEop    (outEop),
    .outValid  (outValid),
    .errCount  (errCount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount++;

  // Capture each transmitted word shortly after the edge that produced it.
  always @(posedge clk) begin
    #1;
    if (outValid === 1'b1) begin
      obsQ.push_back({outSop, outEop, outData});
      obsCyc.push_back(cycleCount);
    end
  end

  // Random line backpressure while randStall is set.
  initial begin
    forever begin
      @(negedge clk);
      if (randStall) portStall = ($urandom_range(0, 2) == 0);
    end
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkValue(input string tag, input logic [63:0] observed,
                            input logic [63:0] expected);
    totalChecks++;
    assert (observed === expected) passedChecks++;
    else begin
      failedChecks++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  function automatic int satInc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  // Drive one word and hold it until the block accepts it. This task returns
  // on the falling edge after the transfer.
  task automatic applyStimulus(input logic [31:0] d, input logic s, input logic e);
    int guard;
    guard   = 0;
    wrData  = d;
    wrSop   = s;
    wrEop   = e;
    wrValid = 1'b1;
    while (wrReady !== 1'b1 && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= BUDGET) checkValue("wrReadyTimeout", guard, 0);
    @(negedge clk);
    wrValid = 1'b0;
    wrSop   = 1'b0;
    wrEop   = 1'b0;
  endtask

  // Packet-level model: an aborted prefix costs one drop. A packet longer
  // than the buffer costs one drop. Any other packet is sent unchanged.
  task automatic sendPacket(input int len, input int abortLen,
                            input logic [31:0] base, input bit randData);
    logic [31:0] w;
    for (int i = 0; i < abortLen; i++) begin
      w = randData ? $urandom : base + 32'h100 + 32'(i);
      applyStimulus(w, (i == 0), 1'b0);
    end
    if (abortLen > 0) errExp = satInc(errExp);
    for (int i = 0; i < len; i++) begin
      w = randData ? $urandom : base + 32'(i);
      applyStimulus(w, (i == 0), (i == len - 1));
      if (len <= DEPTH) expQ.push_back({(i == 0), (i == len - 1), w});
    end
    if (len > DEPTH) errExp = satInc(errExp);
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    while (obsQ.size() < expQ.size() && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    checkValue("drainInTime", (guard < BUDGET), 1);
    repeat (8) @(negedge clk);
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "_count"}, obsQ.size(), expQ.size());
    for (int i = 0; i < expQ.size() && i < obsQ.size(); i++) begin
      checkValue($sformatf("%s_word%0d", tag, i), obsQ[i], expQ[i]);
    end
    checkValue({tag, "_errCount"}, errCount, errExp);
    obsQ.delete();
    expQ.delete();
    obsCyc.delete();
  endtask

  task automatic doReset();
    reset     = 1'b1;
    wrValid   = 1'b0;
    wrSop     = 1'b0;
    wrEop     = 1'b0;
    portStall = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    obsQ.delete();
    expQ.delete();
    obsCyc.delete();
    errExp = 0;
  endtask

  initial begin
    int guard;
    logic [31:0] w;
    wrData = 32'd0;
    doReset();

    $display("[TB] reset state");
    checkValue("rst_outValid", outValid, 0);
    checkValue("rst_outSop", outSop, 0);
    checkValue("rst_outEop", outEop, 0);
    checkValue("rst_outData", outData, 0);
    checkValue("rst_errCount", errCount, 0);
    checkValue("rst_wrReady", wrReady, 1);

    $display("[TB] four-word packet, free line");
    sendPacket(4, 0, 32'hA0, 1'b0);
    checkValue("lat_beforeFirst_outValid", outValid, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkValue($sformatf("pkt4_valid%0d", i), outValid, 1);
      checkValue($sformatf("pkt4_data%0d", i), outData, 32'hA0 + 32'(i));
      checkValue($sformatf("pkt4_sop%0d", i), outSop, (i == 0));
      checkValue($sformatf("pkt4_eop%0d", i), outEop, (i == 3));
    end
    waitDrain();
    checkOutput("pkt4");

    $display("[TB] four-word packet, three stalled cycles");
    sendPacket(4, 0, 32'hA0, 1'b0);
    @(negedge clk);
    checkValue("stall_first", {outValid, outSop, outData}, {2'b11, 32'hA0});
    @(negedge clk);
    checkValue("stall_second", {outValid, outData}, {1'b1, 32'hA1});
    portStall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkValue($sformatf("stall_hold%0d", i), {outValid, outData}, {1'b0, 32'hA1});
    end
    portStall = 1'b0;
    @(negedge clk);
    checkValue("stall_third", {outValid, outData}, {1'b1, 32'hA2});
    @(negedge clk);
    checkValue("stall_fourth", {outValid, outEop, outData}, {2'b11, 32'hA3});
    waitDrain();
    checkOutput("stall");

    $display("[TB] packet cut short by new sop");
    applyStimulus(32'h11, 1'b1, 1'b0);
    applyStimulus(32'h12, 1'b0, 1'b0);
    errExp = satInc(errExp);
    sendPacket(2, 0, 32'h21, 1'b0);
    waitDrain();
    checkOutput("abort");

    $display("[TB] oversize packet then short packet");
    doReset();
    sendPacket(20, 0, 32'h300, 1'b0);
    sendPacket(2, 0, 32'h400, 1'b0);
    waitDrain();
    checkOutput("oversize");

    $display("[TB] three one-word packets back to back");
    sendPacket(1, 0, 32'h51, 1'b0);
    sendPacket(1, 0, 32'h52, 1'b0);
    sendPacket(1, 0, 32'h53, 1'b0);
    waitDrain();
    if (obsCyc.size() >= 3) begin
      checkValue("b2b_gap01", obsCyc[1] - obsCyc[0], 1);
      checkValue("b2b_gap12", obsCyc[2] - obsCyc[1], 1);
    end
    checkOutput("b2b");

    $display("[TB] reset while sending an eight-word packet");
    sendPacket(8, 0, 32'hB0, 1'b0);
    guard = 0;
    while (obsQ.size() < 3 && guard < BUDGET) begin
      @(negedge clk);
      guard++;
    end
    checkValue("midReset_reached", (guard < BUDGET), 1);
    #2;
    reset = 1'b1;
    #1;
    checkValue("midReset_out", {outValid, outSop, outEop, outData}, 35'd0);
    checkValue("midReset_errCount", errCount, 0);
    obsQ.delete();
    expQ.delete();
    obsCyc.delete();
    errExp = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    checkValue("midReset_noOutput", obsQ.size(), 0);

    $display("[TB] randomized packets with random backpressure");
    randStall = 1'b1;
    for (int p = 0; p < 40; p++) begin
      int r;
      int len;
      int abortLen;
      r        = $urandom_range(0, 9);
      len      = (r == 0) ? $urandom_range(DEPTH + 1, DEPTH + 5) : $urandom_range(1, 8);
      abortLen = (r == 1) ? $urandom_range(1, 3) : 0;
      sendPacket(len, abortLen, 32'd0, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    waitDrain();
    randStall = 1'b0;
    @(negedge clk);
    portStall = 1'b0;
    checkOutput("random");

    $display("[TB] drop counter saturation");
    for (int i = 0; i < 260; i++) begin
      w = 32'h600 + 32'(i);
      applyStimulus(w, 1'b1, 1'b0);
      if (i > 0) errExp = satInc(errExp);
    end
    applyStimulus(32'h6FF, 1'b0, 1'b1);
    expQ.push_back({2'b10, 32'h600 + 32'd259});
    expQ.push_back({2'b01, 32'h6FF});
    waitDrain();
    checkOutput("saturate");

    $display("%0d/%0d checks passed", passedChecks, totalChecks);
    $finish;
  end

endmodule
